// File: rtl/sin_nco_pkg.sv
// Shared sizing defaults and elaboration-time helpers for the table-based sine NCO.
// The quarter-wave table is computed here in fixed point so the ROM holds only constants.
package sin_nco_pkg;

   localparam int unsigned DEF_SAMPLE_W   = 16;
   localparam int unsigned DEF_TABLE_CT   = 256;
   localparam int unsigned DEF_TABLE_BITS = 8;
   localparam int unsigned DIV_W          = 16;

   // Fixed-point scale for the table generator; pi * 2**30 rounded.
   localparam int unsigned     FX_BITS = 30;
   localparam longint unsigned PI_FX   = 64'd3373259426;

   function automatic int unsigned midscale(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

   function automatic int unsigned qtr_depth(input int unsigned table_ct);
      return (table_ct / 4) + 1;
   endfunction

   // round(amp * sin(2*pi*j/table_ct)) via a rounded Taylor series, j in 0..table_ct/4.
   function automatic int unsigned quarter_val(input int unsigned j, input int unsigned table_ct,
                                               input int unsigned amp);
      longint unsigned half;
      longint unsigned x;
      longint unsigned x2;
      longint unsigned term;
      longint unsigned acc_pos;
      longint unsigned acc_neg;
      longint unsigned den;
      half    = 64'd1 << (FX_BITS - 1);
      x       = ((PI_FX * 64'(2 * j)) + 64'(table_ct / 2)) / 64'(table_ct);
      x2      = ((x * x) + half) >> FX_BITS;
      term    = x;
      acc_pos = x;
      acc_neg = 64'd0;
      for (int unsigned n = 1; n <= 8; n++) begin
         den  = 64'(2 * n * (2 * n + 1));
         term = ((((term * x2) + half) >> FX_BITS) + (den / 64'd2)) / den;
         if (n[0]) acc_neg = acc_neg + term;
         else      acc_pos = acc_pos + term;
      end
      return 32'(((64'(amp) * (acc_pos - acc_neg)) + half) >> FX_BITS);
   endfunction

endpackage

// File: rtl/sin_nco_if.sv
// Control/sample bundle between the NCO and its consumer (divider in, sample and sync out).
interface sin_nco_if
   import sin_nco_pkg::*;
#(
   parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
);
   logic [DIV_W-1:0]    nco_div;
   logic [SAMPLE_W-1:0] nco_out;
   logic                ncoovfsync;

   modport master (output nco_div, input nco_out, input ncoovfsync);
   modport slave  (input nco_div, output nco_out, output ncoovfsync);
endinterface

// File: rtl/sin_quarter_rom.sv
// Combinational quarter-wave sine magnitude table, entries 0..TABLE_CT/4 inclusive.
// Entry j = round((2**(SAMPLE_W-1)-1) * sin(2*pi*j/TABLE_CT)).
module sin_quarter_rom
   import sin_nco_pkg::*;
#(
   parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
   parameter int unsigned TABLE_CT = DEF_TABLE_CT,
   parameter int unsigned IDX_W    = $clog2(qtr_depth(DEF_TABLE_CT))
) (
   input  logic [IDX_W-1:0]    idx,
   output logic [SAMPLE_W-2:0] val_c
);
   localparam int unsigned DEPTH = qtr_depth(TABLE_CT);
   localparam int unsigned AMP   = midscale(SAMPLE_W) - 1;

   logic [SAMPLE_W-2:0] tab [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_tab
      localparam logic [SAMPLE_W-2:0] ENTRY = (SAMPLE_W-1)'(quarter_val(g, TABLE_CT, AMP));
      assign tab[g] = ENTRY;
   end

   assign val_c = tab[idx];

endmodule

// File: rtl/sin_nco.sv
// Table-based sine NCO: prescaled phase stepping, quarter-wave mirror/sign expansion,
// registered offset-binary sample and a one-clock sync pulse on each period wrap.
module sin_nco
   import sin_nco_pkg::*;
#(
   parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
   parameter int unsigned TABLE_CT   = DEF_TABLE_CT,
   parameter int unsigned TABLE_BITS = DEF_TABLE_BITS
) (
   input logic      clk,
   input logic      rst,
   sin_nco_if.slave bus
);
   localparam int unsigned QIDX_W = TABLE_BITS - 1;
   localparam int unsigned LOW_W  = TABLE_BITS - 2;

   localparam logic [SAMPLE_W-1:0]   MIDSCALE  = SAMPLE_W'(midscale(SAMPLE_W));
   localparam logic [QIDX_W-1:0]     QTR_SPAN  = QIDX_W'(TABLE_CT / 4);
   localparam logic [TABLE_BITS-1:0] PHASE_MAX = TABLE_BITS'(TABLE_CT - 1);

   logic [DIV_W-1:0]      div_cnt;
   logic [TABLE_BITS-1:0] phase;

   logic                  tick_c;
   logic [TABLE_BITS-1:0] phase_nxt_c;
   logic [1:0]            quad_c;
   logic [LOW_W-1:0]      low_c;
   logic [QIDX_W-1:0]     qidx_c;
   logic [SAMPLE_W-2:0]   qval_c;
   logic [SAMPLE_W-1:0]   sample_c;

   sin_quarter_rom #(
      .SAMPLE_W (SAMPLE_W),
      .TABLE_CT (TABLE_CT),
      .IDX_W    (QIDX_W)
   ) u_rom (
      .idx   (qidx_c),
      .val_c (qval_c)
   );

   // >= lets a lowered divider tick at once instead of wrapping the counter.
   always_comb begin
      tick_c      = (bus.nco_div <= DIV_W'(1)) || (div_cnt >= (bus.nco_div - DIV_W'(1)));
      phase_nxt_c = phase + TABLE_BITS'(1);
      quad_c      = phase_nxt_c[TABLE_BITS-1 -: 2];
      low_c       = phase_nxt_c[LOW_W-1:0];
      qidx_c      = quad_c[0] ? (QTR_SPAN - QIDX_W'(low_c)) : QIDX_W'(low_c);
      sample_c    = quad_c[1] ? (MIDSCALE - SAMPLE_W'(qval_c)) : (MIDSCALE + SAMPLE_W'(qval_c));
   end

   // Sample is looked up from phase+1 so it lands on the same edge the phase advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt        <= '0;
         phase          <= '0;
         bus.nco_out    <= MIDSCALE;
         bus.ncoovfsync <= 1'b0;
      end else if (tick_c) begin
         div_cnt        <= '0;
         phase          <= phase_nxt_c;
         bus.nco_out    <= sample_c;
         bus.ncoovfsync <= (phase == PHASE_MAX);
      end else begin
         div_cnt        <= div_cnt + DIV_W'(1);
         bus.ncoovfsync <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sin_nco.sv
// Scoreboard bench for sin_nco: expected steps (value, spacing, sync) are queued from a
// floating-point sine model when the divider is driven and popped as the DUT output steps.
module tb_sin_nco;
   localparam real PI = 3.14159265358979323846;
   localparam int  N  = 256;

   typedef struct {
      logic [15:0] val;
      int          gap;
      logic        sync;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;

   logic [15:0] lut [N];
   exp_t        exp_q [$];
   int          m_phase;

   logic [15:0] obs_val [$];
   int          obs_gap [$];
   logic        obs_sync [$];
   int unsigned obs_cyc [$];
   int          stray_sync;
   bit          timed_out;

   sin_nco_if #(.SAMPLE_W(16)) bus ();

   sin_nco #(.SAMPLE_W(16), .TABLE_CT(256), .TABLE_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int rnd(input real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(0.5 - v);
   endfunction

   function automatic logic [15:0] lut_val(input int k);
      return 16'(32768 + rnd(32767.0 * $sin(2.0 * PI * k / 256.0)));
   endfunction

   // Queue the next n steps of the model phase; first_gap covers leftover prescaler state.
   task automatic push_steps(input int n, input int first_gap, input int gap);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         m_phase = (m_phase + 1) % N;
         e.val   = lut[m_phase];
         e.gap   = (i == 0) ? first_gap : gap;
         e.sync  = (m_phase == 0);
         exp_q.push_back(e);
      end
   endtask

   // Record n output steps; a step is a change of nco_out, gap is clocks since the last one.
   task automatic capture_steps(input int n, input int budget);
      logic [15:0] prev;
      int          gap;
      obs_val.delete(); obs_gap.delete(); obs_sync.delete(); obs_cyc.delete();
      stray_sync = 0;
      timed_out  = 1'b0;
      prev       = bus.nco_out;
      for (int i = 0; i < n && !timed_out; i++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
            if (bus.nco_out === prev && bus.ncoovfsync === 1'b1) stray_sync++;
         end while (bus.nco_out === prev && gap < budget);
         if (bus.nco_out === prev) timed_out = 1'b1;
         else begin
            prev = bus.nco_out;
            obs_val.push_back(prev);
            obs_gap.push_back(gap);
            obs_sync.push_back(bus.ncoovfsync);
            obs_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      bus.nco_div = 16'd16;
      repeat (3) @(negedge clk);
      total++;
      if (bus.nco_out !== 16'h8000) begin
         bad++; $display("FAIL reset_out: got %h want 8000", bus.nco_out);
      end
      total++;
      if (bus.ncoovfsync !== 1'b0) begin
         bad++; $display("FAIL reset_sync: got %b want 0", bus.ncoovfsync);
      end
      rst = 1'b0;
      m_phase = 0;
      push_steps(1, 16, 16);
      capture_steps(1, 40);
      total++;
      if (timed_out) begin bad++; $display("FAIL reset_first_step: got no step want one within 40 clocks"); end
      foreach (obs_val[i]) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_val[i], obs_gap[i], obs_sync[i]} !== {e.val, e.gap, e.sync}) begin
            bad++; $display("FAIL reset_step%0d: got val=%h gap=%0d sync=%b want val=%h gap=%0d sync=%b",
                            i, obs_val[i], obs_gap[i], obs_sync[i], e.val, e.gap, e.sync);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_div16();
      exp_t        e;
      int unsigned sc [$];
      push_steps(511, 16, 16);
      capture_steps(511, 40);
      total++;
      if (timed_out) begin bad++; $display("FAIL div16_timeout: got %0d steps want 511", obs_val.size()); end
      foreach (obs_val[i]) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_val[i], obs_gap[i], obs_sync[i]} !== {e.val, e.gap, e.sync}) begin
            bad++; $display("FAIL div16_step%0d: got val=%h gap=%0d sync=%b want val=%h gap=%0d sync=%b",
                            i, obs_val[i], obs_gap[i], obs_sync[i], e.val, e.gap, e.sync);
         end
         if (obs_sync[i] === 1'b1) begin
            sc.push_back(obs_cyc[i]);
            total++;
            if (obs_val[i] !== 16'h8000) begin
               bad++; $display("FAIL div16_sync_value: got %h want 8000", obs_val[i]);
            end
         end
      end
      exp_q.delete();
      total++;
      if (sc.size() != 2 || (sc.size() == 2 && sc[1] - sc[0] != 4096)) begin
         bad++; $display("FAIL div16_sync_period: got %0d pulses spacing %0d want 2 pulses spacing 4096",
                         sc.size(), (sc.size() == 2) ? sc[1] - sc[0] : 0);
      end
      total++;
      if (stray_sync != 0) begin bad++; $display("FAIL div16_stray_sync: got %0d want 0", stray_sync); end
   endtask

   task automatic test_div1();
      exp_t        e;
      int unsigned sc [$];
      logic [16:0] s;
      logic [15:0] want_q [4];
      want_q[0] = 16'h8000; want_q[1] = 16'hFFFF; want_q[2] = 16'h8000; want_q[3] = 16'h0001;
      bus.nco_div = 16'd1;
      push_steps(512, 1, 1);
      capture_steps(512, 4);
      total++;
      if (timed_out) begin bad++; $display("FAIL div1_timeout: got %0d steps want 512", obs_val.size()); end
      foreach (obs_val[i]) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_val[i], obs_gap[i], obs_sync[i]} !== {e.val, e.gap, e.sync}) begin
            bad++; $display("FAIL div1_step%0d: got val=%h gap=%0d sync=%b want val=%h gap=%0d sync=%b",
                            i, obs_val[i], obs_gap[i], obs_sync[i], e.val, e.gap, e.sync);
         end
         if (obs_sync[i] === 1'b1) sc.push_back(obs_cyc[i]);
      end
      exp_q.delete();
      total++;
      if (sc.size() != 2 || (sc.size() == 2 && sc[1] - sc[0] != 256)) begin
         bad++; $display("FAIL div1_sync_period: got %0d pulses spacing %0d want 2 pulses spacing 256",
                         sc.size(), (sc.size() == 2) ? sc[1] - sc[0] : 0);
      end
      if (obs_val.size() >= N) begin
         // Observation i holds phase (i+1) mod 256.
         for (int q = 0; q < 4; q++) begin
            total++;
            if (obs_val[(q * 64 + 255) % N] !== want_q[q]) begin
               bad++; $display("FAIL div1_quadrant_sample%0d: got %h want %h", q * 64,
                               obs_val[(q * 64 + 255) % N], want_q[q]);
            end
         end
         for (int k = 1; k < 128; k++) begin
            s = 17'(obs_val[k - 1]) + 17'(obs_val[k + 127]);
            total++;
            if (s !== 17'h10000) begin
               bad++; $display("FAIL odd_symmetry_k%0d: got sum %h want 10000", k, s);
            end
         end
      end
   endtask

   task automatic test_div0();
      exp_t        e;
      int unsigned start;
      start = cyc;
      bus.nco_div = 16'd0;
      push_steps(256, 1, 1);
      capture_steps(256, 4);
      total++;
      if (timed_out) begin bad++; $display("FAIL div0_timeout: got %0d steps want 256", obs_val.size()); end
      foreach (obs_val[i]) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_val[i], obs_gap[i], obs_sync[i]} !== {e.val, e.gap, e.sync}) begin
            bad++; $display("FAIL div0_step%0d: got val=%h gap=%0d sync=%b want val=%h gap=%0d sync=%b",
                            i, obs_val[i], obs_gap[i], obs_sync[i], e.val, e.gap, e.sync);
         end
      end
      exp_q.delete();
      if (obs_cyc.size() == 256) begin
         total++;
         if (obs_cyc[255] - start != 256) begin
            bad++; $display("FAIL div0_sync_period: got %0d want 256", obs_cyc[255] - start);
         end
      end
   endtask

   task automatic test_div_change();
      exp_t e;
      bus.nco_div = 16'd188;
      repeat (100) @(negedge clk);
      total++;
      if (bus.nco_out !== lut[m_phase]) begin
         bad++; $display("FAIL divchg_hold: got %h want %h", bus.nco_out, lut[m_phase]);
      end
      bus.nco_div = 16'd50;
      push_steps(3, 1, 50);
      capture_steps(3, 60);
      total++;
      if (timed_out) begin bad++; $display("FAIL divchg_timeout: got %0d steps want 3", obs_val.size()); end
      foreach (obs_val[i]) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_val[i], obs_gap[i], obs_sync[i]} !== {e.val, e.gap, e.sync}) begin
            bad++; $display("FAIL divchg_step%0d: got val=%h gap=%0d sync=%b want val=%h gap=%0d sync=%b",
                            i, obs_val[i], obs_gap[i], obs_sync[i], e.val, e.gap, e.sync);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bus.nco_div = 16'd4;
      push_steps(5, 4, 4);
      capture_steps(5, 10);
      total++;
      if (timed_out) begin bad++; $display("FAIL rstmid_pre_timeout: got %0d steps want 5", obs_val.size()); end
      foreach (obs_val[i]) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_val[i], obs_gap[i], obs_sync[i]} !== {e.val, e.gap, e.sync}) begin
            bad++; $display("FAIL rstmid_pre_step%0d: got val=%h gap=%0d sync=%b want val=%h gap=%0d sync=%b",
                            i, obs_val[i], obs_gap[i], obs_sync[i], e.val, e.gap, e.sync);
         end
      end
      exp_q.delete();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({bus.nco_out, bus.ncoovfsync} !== {16'h8000, 1'b0}) begin
         bad++; $display("FAIL rstmid_async: got out=%h sync=%b want out=8000 sync=0", bus.nco_out, bus.ncoovfsync);
      end
      repeat (2) @(negedge clk);
      total++;
      if ({bus.nco_out, bus.ncoovfsync} !== {16'h8000, 1'b0}) begin
         bad++; $display("FAIL rstmid_held: got out=%h sync=%b want out=8000 sync=0", bus.nco_out, bus.ncoovfsync);
      end
      rst = 1'b0;
      m_phase = 0;
      push_steps(1, 4, 4);
      capture_steps(1, 10);
      total++;
      if (timed_out) begin bad++; $display("FAIL rstmid_post_timeout: got no step want one within 10 clocks"); end
      foreach (obs_val[i]) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_val[i], obs_gap[i], obs_sync[i]} !== {e.val, e.gap, e.sync}) begin
            bad++; $display("FAIL rstmid_post_step%0d: got val=%h gap=%0d sync=%b want val=%h gap=%0d sync=%b",
                            i, obs_val[i], obs_gap[i], obs_sync[i], e.val, e.gap, e.sync);
         end
      end
      exp_q.delete();
      total++;
      if (stray_sync != 0) begin bad++; $display("FAIL rstmid_stray_sync: got %0d want 0", stray_sync); end
   endtask

   task automatic test_div188();
      exp_t        e;
      int unsigned start;
      // Fast-forward to the period wrap so the long run starts on a sync edge.
      bus.nco_div = 16'd1;
      push_steps(N - 1 - m_phase + 1, 1, 1);
      capture_steps(exp_q.size(), 4);
      total++;
      if (timed_out || exp_q.size() != obs_val.size() || obs_sync[obs_sync.size() - 1] !== 1'b1) begin
         bad++; $display("FAIL div188_align: got %0d steps last sync=%b want %0d steps last sync=1",
                         obs_val.size(), (obs_sync.size() > 0) ? obs_sync[obs_sync.size() - 1] : 1'bx, exp_q.size());
      end
      exp_q.delete();
      start = cyc;
      bus.nco_div = 16'd188;
      push_steps(256, 188, 188);
      capture_steps(256, 200);
      total++;
      if (timed_out) begin bad++; $display("FAIL div188_timeout: got %0d steps want 256", obs_val.size()); end
      foreach (obs_val[i]) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_val[i], obs_gap[i], obs_sync[i]} !== {e.val, e.gap, e.sync}) begin
            bad++; $display("FAIL div188_step%0d: got val=%h gap=%0d sync=%b want val=%h gap=%0d sync=%b",
                            i, obs_val[i], obs_gap[i], obs_sync[i], e.val, e.gap, e.sync);
         end
      end
      exp_q.delete();
      if (obs_cyc.size() == 256) begin
         total++;
         if (obs_cyc[255] - start != 48128) begin
            bad++; $display("FAIL div188_sync_period: got %0d want 48128", obs_cyc[255] - start);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) lut[k] = lut_val(k);
      test_reset();
      test_div16();
      test_div1();
      test_div0();
      test_div_change();
      test_reset_mid();
      test_div188();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
